control_de_relojes: RTL and testbench
=====================================

# control_de_relojes

Run/stop and divide-ratio controller for the 8b/32b conversion clock domain. It replaces free-running divided clocks with a single-cycle clock-enable strobe on `CLK`, at a selectable ratio of 1, 2, 4, 8, 16 or 32. Ratio changes and stops take effect only at the 32-cycle frame boundary, so no consumer ever sees a truncated period. It sits between the link control logic, which issues start, stop and ratio requests, and the packing datapath, which consumes `EN_STROBE` and `PHASE`.

## Interface
- `CNT_W`, default 5: phase counter width; maximum ratio is 2^CNT_W.
- `CLK` in 1: sole clock, rising edge.
- `RESET_L` in 1: reset, synchronous, active-low.
- `START` in 1: run request, level, sampled every cycle.
- `STOP` in 1: stop request, level, sampled every cycle.
- `DIV_REQ` in 1: ratio-change request, held until `DIV_ACK`.
- `DIV_SEL` in 3: requested log2 ratio, 0..CNT_W; values above CNT_W clamp to CNT_W.
- `DIV_ACK` out 1: one-cycle pulse; the new ratio is active in this cycle.
- `RUNNING` out 1: strobe generation active.
- `EN_STROBE` out 1: one-cycle enable, once per 2^DIV_CUR cycles while running.
- `PHASE` out CNT_W: current frame position.
- `DIV_CUR` out 3: ratio in force.
- `CLK_DIV` out CNT_W: only with `CLK_DIV_OUT_EN`; see Configuration.

## Operation
- States:
  - IDLE: count held at 0.
  - RUN: count increments by 1 per cycle, wrapping 2^CNT_W-1 to 0.
  - SWITCH: RUN with a ratio change pending.
  - STOPPING: RUN with a stop pending; may also carry a pending ratio change.
- Frame boundary ("wrap"): a running state with count == 2^CNT_W-1.
- Mask: mask = 2^DIV_CUR - 1.
- `EN_STROBE` = running && (PHASE & mask) == mask.
  - Decoded from registers only; no input-to-output combinational path.
  - Ratio 0 gives `EN_STROBE` on every running cycle.
- IDLE + `START`: next cycle RUN, `RUNNING` = 1, PHASE = 0. `STOP` is ignored in IDLE.
- IDLE + accepted `DIV_REQ`: next cycle `DIV_CUR` = clamped `DIV_SEL` and `DIV_ACK` = 1.
- Request acceptance: `DIV_REQ` is accepted only when `DIV_ACK` is 0.
  - In RUN, the clamped `DIV_SEL` is captured into a pending register on the acceptance cycle; state goes to SWITCH.
  - A `DIV_REQ` arriving while a change is already pending is not accepted. The requester holds it until `DIV_ACK` and deasserts it in the ACK cycle.
- `STOP` in RUN or SWITCH: state goes to STOPPING and keeps any pending change.
- At wrap:
  - A pending change is loaded into `DIV_CUR`, and `DIV_ACK` pulses in the next cycle.
  - A pending stop moves the block to IDLE in the next cycle: `RUNNING` = 0, PHASE = 0.
- `START` in STOPPING cancels the stop. If `START` and `STOP` are high together while running, `STOP` wins.
- Every ratio divides 2^CNT_W, so the wrap cycle always carries `EN_STROBE`. The last period before a stop or a ratio change is therefore always complete.

## Timing
- Reset values: state IDLE, PHASE 0, `DIV_CUR` 0, `DIV_ACK` 0, `RUNNING` 0, `EN_STROBE` 0, pending flags cleared, `CLK_DIV` 0.
- Reset mid-request: a pending change is dropped and no `DIV_ACK` is issued.
- Latencies:
  - `START` to `RUNNING`: 1 cycle.
  - `DIV_REQ` to `DIV_ACK` while running: 1 to 2^CNT_W cycles, i.e. 1..32 for the default.
  - `STOP` to `RUNNING` low: 1 to 2^CNT_W cycles.
- In the first cycle after `DIV_ACK` was raised while running, PHASE = 0 and the new ratio governs `EN_STROBE`.

## Configuration
- `CLK_DIV_OUT_EN` defined: `CLK_DIV` port present, `CLK_DIV` = PHASE.
  - Bit i is a 50% clock at CLK/2^(i+1), the same waveform as a T-flip-flop divider chain.
  - Held at 0 in IDLE.
- `CLK_DIV_OUT_EN` undefined: port absent; all other behaviour identical.

## Structure
- Package `control_de_relojes_pkg` holds:
  - the state encoding;
  - `DIV_W` = 3;
  - the ratio clamp constant;
  - the default `CNT_W`.
- One sub-module, `contador_fase`: CNT_W-bit counter with synchronous clear, enable and a wrap flag output. The controller FSM, the pending registers and the strobe decode stay in the top module.

## Test plan
- Reset, then `START` with ratio 0: `RUNNING` = 1 one cycle later; `EN_STROBE` high every cycle; PHASE counts 0..31 and wraps.
- In IDLE, `DIV_REQ` with `DIV_SEL` = 2, then `START`: `DIV_ACK` one cycle after the request; `EN_STROBE` at PHASE 3, 7, 11, ….
- Running at ratio 1, `DIV_REQ` at PHASE 10 with `DIV_SEL` = 7:
  - `DIV_ACK` in the cycle after PHASE 31;
  - `DIV_CUR` = 5 (clamped);
  - `EN_STROBE` only at PHASE 31 thereafter.
- `STOP` at PHASE 5 with ratio 3: strobes continue at PHASE 7, 15, 23, 31; `RUNNING` = 0 and PHASE = 0 in the next cycle. Repeat with `START` reasserted at PHASE 20: the stop is cancelled and the block keeps running.
- `STOP` and `DIV_REQ` (ratio 4) together at PHASE 0: `DIV_ACK` and `RUNNING` low in the same cycle after PHASE 31; `DIV_CUR` = 4.
- `RESET_L` low for 1 cycle while in SWITCH: next cycle all outputs at reset values, no `DIV_ACK`. With `CLK_DIV_OUT_EN` defined, check `CLK_DIV[0]` toggling every cycle while running.

Source files
------------

// File: rtl/control_de_relojes_pkg.sv
// Shared types and constants for the control_de_relojes clock-enable controller.
package control_de_relojes_pkg;

  localparam int DIV_W     = 3;
  localparam int CNT_W_DEF = 5;

  // Largest log2 ratio accepted for the default counter width.
  localparam logic [DIV_W-1:0] DIV_CLAMP = DIV_W'(CNT_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SWITCH,
    ST_STOPPING
  } state_e;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] sel,
                                                 input logic [DIV_W-1:0] lim);
    return (sel > lim) ? lim : sel;
  endfunction

endpackage

// File: rtl/control_de_relojes_contador_fase.sv
// Frame phase counter: synchronous clear, count enable, and a flag on the last phase.
module contador_fase
  #(parameter int CNT_W = 5)
  (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o
  );

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i)
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;
  assign wrap_o  = en_i && (count_q == '1);

endmodule

// File: rtl/control_de_relojes.sv
// Run/stop and divide-ratio controller producing a clock-enable strobe.
// Optional CLK_DIV output (a copy of PHASE) is built when CLK_DIV_OUT_EN is defined.
module control_de_relojes
  import control_de_relojes_pkg::*;
  #(parameter int CNT_W = CNT_W_DEF)
  (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             START,
    input  logic             STOP,
    input  logic             DIV_REQ,
    input  logic [DIV_W-1:0] DIV_SEL,
    output logic             DIV_ACK,
    output logic             RUNNING,
    output logic             EN_STROBE,
    output logic [CNT_W-1:0] PHASE,
`ifdef CLK_DIV_OUT_EN
    output logic [CNT_W-1:0] CLK_DIV,
`endif
    output logic [DIV_W-1:0] DIV_CUR
  );

  localparam logic [DIV_W-1:0] DIV_LIM =
    (CNT_W == CNT_W_DEF) ? DIV_CLAMP : DIV_W'(CNT_W);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;

  logic             running, cnt_wrap, accept, chg, stop_req;
  logic [DIV_W-1:0] sel_clamped, chg_val;
  logic [CNT_W-1:0] count, mask;

  contador_fase #(.CNT_W(CNT_W)) u_contador_fase (
    .clk_i   (CLK),
    .rst_ni  (RESET_L),
    .clr_i   (!running),
    .en_i    (running),
    .count_o (count),
    .wrap_o  (cnt_wrap)
  );

  assign running     = (state_q != ST_IDLE);
  assign sel_clamped = clamp_div(DIV_SEL, DIV_LIM);
  assign accept      = DIV_REQ && !ack_q && !pend_q;
  // A request accepted on the wrap cycle itself is applied at that same wrap.
  assign chg         = pend_q || accept;
  assign chg_val     = pend_q ? pend_val_q : sel_clamped;
  assign stop_req    = STOP || ((state_q == ST_STOPPING) && !START);

  always_comb begin
    state_d    = state_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          div_cur_d = sel_clamped;
          ack_d     = 1'b1;
        end
        if (START)
          state_d = ST_RUN;
      end
      default: begin
        if (cnt_wrap) begin
          if (chg) begin
            div_cur_d = chg_val;
            ack_d     = 1'b1;
          end
          pend_d  = 1'b0;
          state_d = stop_req ? ST_IDLE : ST_RUN;
        end else begin
          pend_d     = chg;
          pend_val_d = chg_val;
          if (stop_req)
            state_d = ST_STOPPING;
          else if (chg)
            state_d = ST_SWITCH;
          else
            state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_q    <= ST_IDLE;
      div_cur_q  <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < CNT_W; i++)
      mask[i] = (i < int'(div_cur_q));
  end

  assign EN_STROBE = running && ((count & mask) == mask);
  assign PHASE     = count;
  assign RUNNING   = running;
  assign DIV_ACK   = ack_q;
  assign DIV_CUR   = div_cur_q;
`ifdef CLK_DIV_OUT_EN
  assign CLK_DIV   = count;
`endif

endmodule

// File: tb/tb_control_de_relojes.sv
// Self-checking bench for control_de_relojes: directed scenarios plus random traffic
// compared every cycle against a frame-level behavioural model.
module tb_control_de_relojes;

  localparam int PMAX = 31;
  localparam int DMAX = 5;

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       DIV_REQ = 1'b0;
  logic [2:0] DIV_SEL = 3'd0;
  logic       DIV_ACK, RUNNING, EN_STROBE;
  logic [4:0] PHASE;
  logic [2:0] DIV_CUR;
`ifdef CLK_DIV_OUT_EN
  logic [4:0] CLK_DIV;
`endif

  int total = 0;
  int bad = 0;

  // behavioural model state
  int mRun = 0, mPhase = 0, mDiv = 0, mPend = 0, mPendVal = 0, mStop = 0, mAck = 0;

  control_de_relojes dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .START     (START),
    .STOP      (STOP),
    .DIV_REQ   (DIV_REQ),
    .DIV_SEL   (DIV_SEL),
    .DIV_ACK   (DIV_ACK),
    .RUNNING   (RUNNING),
    .EN_STROBE (EN_STROBE),
    .PHASE     (PHASE),
`ifdef CLK_DIV_OUT_EN
    .CLK_DIV   (CLK_DIV),
`endif
    .DIV_CUR   (DIV_CUR)
  );

  always #5 CLK = ~CLK;

  function automatic int clampSel(input int s);
    return (s > DMAX) ? DMAX : s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic rq, input int sel);
    START   = st;
    STOP    = sp;
    DIV_REQ = rq;
    DIV_SEL = 3'(sel);
  endtask

  // Advances the model by one clock using the inputs present at the edge.
  task automatic modelStep();
    int newAck;
    if (!RESET_L) begin
      mRun = 0; mPhase = 0; mDiv = 0; mPend = 0; mPendVal = 0; mStop = 0; mAck = 0;
    end else if (mRun == 0) begin
      newAck = 0;
      if (DIV_REQ && mAck == 0) begin
        mDiv = clampSel(int'(DIV_SEL));
        newAck = 1;
      end
      mAck = newAck;
      if (START) mRun = 1;
      mPhase = 0;
    end else begin
      if (DIV_REQ && mAck == 0 && mPend == 0) begin
        mPend = 1;
        mPendVal = clampSel(int'(DIV_SEL));
      end
      if (STOP) mStop = 1;
      else if (START) mStop = 0;
      if (mPhase == PMAX) begin
        mAck = mPend;
        if (mPend != 0) mDiv = mPendVal;
        mPend = 0;
        if (mStop != 0) mRun = 0;
        mStop = 0;
        mPhase = 0;
      end else begin
        mAck = 0;
        mPhase++;
      end
    end
  endtask

  task automatic checkOutput();
    int expStrobe;
    expStrobe = (mRun != 0 && ((mPhase + 1) % (1 << mDiv)) == 0) ? 1 : 0;
    check("RUNNING", 32'(RUNNING), 32'(mRun));
    check("PHASE", 32'(PHASE), 32'(mPhase));
    check("DIV_CUR", 32'(DIV_CUR), 32'(mDiv));
    check("DIV_ACK", 32'(DIV_ACK), 32'(mAck));
    check("EN_STROBE", 32'(EN_STROBE), 32'(expStrobe));
`ifdef CLK_DIV_OUT_EN
    check("CLK_DIV", 32'(CLK_DIV), 32'(mPhase));
`endif
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
    modelStep();
    checkOutput();
  endtask

  task automatic waitPhase(input int p, input int maxc);
    int n = 0;
    while (int'(PHASE) != p && n < maxc) begin
      stepCycle();
      n++;
    end
    check("wait_phase", 32'(PHASE), 32'(p));
  endtask

  task automatic waitAck(input int maxc);
    int n = 0;
    do begin
      stepCycle();
      n++;
    end while (!DIV_ACK && n < maxc);
    check("wait_ack", 32'(DIV_ACK), 32'd1);
  endtask

  initial begin
    int n;
    logic prevBit;

    // reset values
    applyStimulus(0, 0, 0, 0);
    RESET_L = 1'b0;
    repeat (2) stepCycle();
    check("rst_running", 32'(RUNNING), 0);
    check("rst_phase", 32'(PHASE), 0);
    check("rst_divcur", 32'(DIV_CUR), 0);
    check("rst_ack", 32'(DIV_ACK), 0);
    check("rst_strobe", 32'(EN_STROBE), 0);

    // start at ratio 0: strobe every cycle, phase wraps
    RESET_L = 1'b1;
    applyStimulus(1, 0, 0, 0);
    stepCycle();
    check("start_running", 32'(RUNNING), 1);
    check("start_phase", 32'(PHASE), 0);
    check("start_strobe", 32'(EN_STROBE), 1);
    applyStimulus(0, 0, 0, 0);
`ifdef CLK_DIV_OUT_EN
    prevBit = CLK_DIV[0];
    stepCycle();
    check("clkdiv0_toggle", 32'(CLK_DIV[0]), 32'(!prevBit));
    prevBit = CLK_DIV[0];
    stepCycle();
    check("clkdiv0_toggle2", 32'(CLK_DIV[0]), 32'(!prevBit));
`else
    prevBit = 1'b0;
`endif
    waitPhase(31, 40);
    stepCycle();
    check("wrap_phase", 32'(PHASE), 0);
    check("wrap_strobe", 32'(EN_STROBE), 1);

    // move to ratio 1, then request 7 at phase 10 (clamps to 5)
    applyStimulus(0, 0, 1, 1);
    waitAck(40);
    check("ratio1_divcur", 32'(DIV_CUR), 1);
    applyStimulus(0, 0, 0, 0);
    waitPhase(10, 40);
    applyStimulus(0, 0, 1, 7);
    waitAck(40);
    check("clamp_phase", 32'(PHASE), 0);
    check("clamp_divcur", 32'(DIV_CUR), 5);
    applyStimulus(0, 0, 0, 0);
    n = int'(EN_STROBE);
    repeat (31) begin
      stepCycle();
      n += int'(EN_STROBE);
    end
    check("ratio5_strobes", 32'(n), 1);

    // stop at phase 5 with ratio 3: completes the frame
    applyStimulus(0, 0, 1, 3);
    waitAck(40);
    applyStimulus(0, 0, 0, 0);
    waitPhase(5, 40);
    applyStimulus(0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 40 && RUNNING; k++) begin
      n += int'(EN_STROBE);
      stepCycle();
    end
    check("stop_running", 32'(RUNNING), 0);
    check("stop_strobes", 32'(n), 4);
    check("stop_phase", 32'(PHASE), 0);

    // stop then cancel by START at phase 20
    applyStimulus(1, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0);
    waitPhase(5, 40);
    applyStimulus(0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0);
    waitPhase(20, 40);
    applyStimulus(1, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0);
    repeat (40) stepCycle();
    check("cancel_running", 32'(RUNNING), 1);

    // STOP and DIV_REQ together at phase 0
    waitPhase(0, 40);
    applyStimulus(0, 1, 1, 4);
    stepCycle();
    applyStimulus(0, 0, 1, 4);
    waitAck(40);
    check("stopchg_running", 32'(RUNNING), 0);
    check("stopchg_divcur", 32'(DIV_CUR), 4);
    applyStimulus(0, 0, 0, 0);

    // reset while a change is pending
    applyStimulus(1, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0);
    repeat (3) stepCycle();
    applyStimulus(0, 0, 1, 1);
    stepCycle();
    RESET_L = 1'b0;
    applyStimulus(0, 0, 0, 0);
    stepCycle();
    check("midrst_running", 32'(RUNNING), 0);
    check("midrst_ack", 32'(DIV_ACK), 0);
    check("midrst_divcur", 32'(DIV_CUR), 0);
    check("midrst_phase", 32'(PHASE), 0);
    RESET_L = 1'b1;
    repeat (3) stepCycle();
    check("midrst_noack", 32'(DIV_ACK), 0);

    // ratio change in IDLE, then start
    applyStimulus(0, 0, 1, 2);
    stepCycle();
    check("idlechg_ack", 32'(DIV_ACK), 1);
    check("idlechg_divcur", 32'(DIV_CUR), 2);
    applyStimulus(1, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0);
    check("idlechg_phase0_strobe", 32'(EN_STROBE), 0);
    waitPhase(3, 10);
    check("idlechg_phase3_strobe", 32'(EN_STROBE), 1);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      RESET_L = ($urandom_range(0, 499) != 0);
      START   = ($urandom_range(0, 7) == 0);
      STOP    = ($urandom_range(0, 15) == 0);
      if (DIV_REQ && DIV_ACK)
        DIV_REQ = 1'b0;
      else if (!DIV_REQ && $urandom_range(0, 9) == 0) begin
        DIV_REQ = 1'b1;
        DIV_SEL = 3'($urandom_range(0, 7));
      end
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
